wb_timeout_reg: RTL and testbench

Registered Wishbone slice with bus-timeout watchdog. It sits directly downstream of the 2-port arbiter, between the arbiter's slave-side output and the shared slave.
- Breaks the combinational path through the arbiter.
- Guarantees every accepted cycle terminates: if the slave never responds, it returns ERR to the granted master so the arbiter's grant is released.

---
 rtl/wb_timeout_reg.sv | 155 +++++++++++++++
 tb/tb_wb_timeout_reg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timeout_reg.sv
// wb_timeout_reg: registered Wishbone slice with a bus-timeout watchdog.
// Sits between the arbiter's slave-side output and the shared slave. It
// registers the request and response paths and forces an ERR to the master
// when the slave does not respond within TIMEOUT strobe cycles, so the
// arbiter's grant is always released.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wbm_*_i / wbm_*_o   upstream (arbiter) side; responses are registered
//   wbs_*_o / wbs_*_i   downstream (slave) side; request is registered
//   timeout_o           (WB_TIMEOUT_STATUS_EN only) pulse with a forced ERR
//   timeout_cnt_o       (WB_TIMEOUT_STATUS_EN only) saturating timeout count
//
// Optional feature macro: WB_TIMEOUT_STATUS_EN
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no cycle in flight; waiting for wbm_cyc_i & wbm_stb_i
// BUSY  | request presented to slave; waiting for response/timeout
// RESP  | one-cycle response pulse to master; no new request accepted
module wb_timeout_reg #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT      = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  input  logic                    wbm_cyc_i,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o
`ifdef WB_TIMEOUT_STATUS_EN
  ,
  output logic                    timeout_o,
  output logic [15:0]             timeout_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  // Last counter value before the forced ERR; counter is 0 on the first
  // strobe cycle, so TIMEOUT-1 is the TIMEOUT-th strobe cycle.
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        slv_rsp_d;
  logic        to_hit_d;

  assign slv_rsp_d = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign to_hit_d  = TO_EN && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wbm_dat_o     <= '0;
      wbm_ack_o     <= 1'b0;
      wbm_err_o     <= 1'b0;
      wbm_rty_o     <= 1'b0;
      wbs_adr_o     <= '0;
      wbs_dat_o     <= '0;
      wbs_we_o      <= 1'b0;
      wbs_sel_o     <= '0;
      wbs_stb_o     <= 1'b0;
      wbs_cyc_o     <= 1'b0;
`ifdef WB_TIMEOUT_STATUS_EN
      timeout_o     <= 1'b0;
      timeout_cnt_o <= '0;
`endif
    end else begin
      // Response outputs are single-cycle pulses by default.
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
`ifdef WB_TIMEOUT_STATUS_EN
      timeout_o <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          wbs_cyc_o <= 1'b0;
          wbs_stb_o <= 1'b0;
          if (wbm_cyc_i && wbm_stb_i) begin
            wbs_adr_o <= wbm_adr_i;
            wbs_dat_o <= wbm_dat_i;
            wbs_we_o  <= wbm_we_i;
            wbs_sel_o <= wbm_sel_i;
            wbs_cyc_o <= 1'b1;
            wbs_stb_o <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          // Abort beats a same-cycle slave response; slave response beats
          // a same-cycle timeout.
          if (!wbm_cyc_i) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            state_q   <= S_IDLE;
          end else if (slv_rsp_d) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbm_dat_o <= wbs_dat_i;
            wbm_ack_o <= wbs_ack_i;
            wbm_err_o <= !wbs_ack_i && wbs_err_i;
            wbm_rty_o <= !wbs_ack_i && !wbs_err_i && wbs_rty_i;
            state_q   <= S_RESP;
          end else if (to_hit_d) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbm_err_o <= 1'b1;
`ifdef WB_TIMEOUT_STATUS_EN
            timeout_o <= 1'b1;
            if (timeout_cnt_o != 16'hFFFF) timeout_cnt_o <= timeout_cnt_o + 16'd1;
`endif
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          wbs_cyc_o <= 1'b0;
          wbs_stb_o <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_timeout_reg.sv
module tb_wb_timeout_reg;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic        wbm_we_i, wbm_stb_i, wbm_cyc_i;
  logic [3:0]  wbm_sel_i;
  logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0] wbs_adr_o, wbs_dat_i, wbs_dat_o;
  logic        wbs_we_o, wbs_stb_o, wbs_cyc_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_ack_i, wbs_err_i, wbs_rty_i;
`ifdef WB_TIMEOUT_STATUS_EN
  logic        timeout_o;
  logic [15:0] timeout_cnt_o;
`endif

  int passed = 0;
  int total  = 0;
  int exp_to_cnt = 0;

  wb_timeout_reg #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
    .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbm_cyc_i(wbm_cyc_i),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .wbs_cyc_o(wbs_cyc_o)
`ifdef WB_TIMEOUT_STATUS_EN
    , .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_we_i = 1'b0; wbm_sel_i = '0;
    wbm_stb_i = 1'b0; wbm_cyc_i = 1'b0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
  endtask

  function automatic logic all_outputs_zero();
    logic z;
    z = (wbm_dat_o == 0) && !wbm_ack_o && !wbm_err_o && !wbm_rty_o &&
        (wbs_adr_o == 0) && (wbs_dat_o == 0) && !wbs_we_o && (wbs_sel_o == 0) &&
        !wbs_stb_o && !wbs_cyc_o;
`ifdef WB_TIMEOUT_STATUS_EN
    z = z && !timeout_o && (timeout_cnt_o == 0);
`endif
    return z;
  endfunction

  // One master transfer. k = strobe cycle (1-based) on which the slave
  // responds with flags {rty,err,ack}; k=0 means never. a = strobe cycle on
  // which the master drops cyc (0 = never). The expected outcome is derived
  // from the transfer rules alone: the first of abort / slave response /
  // TIMEOUT-th strobe cycle decides the result.
  task automatic run_txn(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                         input logic [3:0] sel, input int k, input logic [2:0] flags,
                         input logic [31:0] rdata, input int a, input string name);
    int eff, exp_n, n, first_c, rsp_c, n_ack, n_err, n_rty, n_to;
    bit slave_rsp, aborted, exp_ack, exp_err, exp_rty, timed_out, stable_bad;
    logic [31:0] dat_at_rsp;

    slave_rsp = (k >= 1) && (k <= TO);
    eff       = slave_rsp ? k : TO;
    aborted   = (a >= 1) && (a <= eff);
    exp_n     = aborted ? a : eff;
    exp_ack   = !aborted && slave_rsp && flags[0];
    exp_err   = !aborted && (!slave_rsp || (!flags[0] && flags[1]));
    exp_rty   = !aborted && slave_rsp && (flags == 3'b100);
    timed_out = !aborted && !slave_rsp;
    if (timed_out && exp_to_cnt < 65535) exp_to_cnt++;

    wbm_adr_i = adr; wbm_dat_i = dat; wbm_we_i = we; wbm_sel_i = sel;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    n = 0; first_c = -1; rsp_c = -1; n_ack = 0; n_err = 0; n_rty = 0; n_to = 0;
    stable_bad = 1'b0; dat_at_rsp = '0;

    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (wbs_stb_o) begin
        n++;
        if (first_c < 0) first_c = c;
        if (wbs_adr_o !== adr || wbs_dat_o !== dat || wbs_we_o !== we ||
            wbs_sel_o !== sel || wbs_cyc_o !== 1'b1) stable_bad = 1'b1;
      end
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
        rsp_c = c; dat_at_rsp = wbm_dat_o;
      end
      n_ack += int'(wbm_ack_o); n_err += int'(wbm_err_o); n_rty += int'(wbm_rty_o);
`ifdef WB_TIMEOUT_STATUS_EN
      n_to += int'(timeout_o);
`endif
      // slave side: respond on strobe cycle k, inject ignored junk when idle
      wbs_dat_i = $urandom;
      if (wbs_stb_o && n == k) begin
        {wbs_rty_i, wbs_err_i, wbs_ack_i} = flags;
        wbs_dat_i = rdata;
      end else if (!wbs_stb_o) begin
        {wbs_rty_i, wbs_err_i, wbs_ack_i} = 3'($urandom_range(0, 7));
      end else begin
        {wbs_rty_i, wbs_err_i, wbs_ack_i} = 3'b000;
      end
      // master side
      if ((wbs_stb_o && a != 0 && n == a) || wbm_ack_o || wbm_err_o || wbm_rty_o) begin
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
      end
    end
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;

    total++;
    if (first_c !== 1) $display("FAIL %s stb_latency: first stb cycle %0d, want 1", name, first_c);
    else passed++;
    total++;
    if (n !== exp_n) $display("FAIL %s stb_cycles: got %0d, want %0d", name, n, exp_n);
    else passed++;
    total++;
    if (stable_bad) $display("FAIL %s wbs_stable: request fields changed or wrong, got 1 want 0", name);
    else passed++;
    total++;
    if (n_ack !== int'(exp_ack) || n_err !== int'(exp_err) || n_rty !== int'(exp_rty))
      $display("FAIL %s resp_pulses: ack/err/rty got %0d/%0d/%0d want %0d/%0d/%0d",
               name, n_ack, n_err, n_rty, exp_ack, exp_err, exp_rty);
    else passed++;
    if (!aborted) begin
      total++;
      if (rsp_c !== exp_n + 1) $display("FAIL %s resp_latency: got cycle %0d, want %0d", name, rsp_c, exp_n + 1);
      else passed++;
    end
    if (slave_rsp && !aborted) begin
      total++;
      if (dat_at_rsp !== rdata) $display("FAIL %s rdata: got %h, want %h", name, dat_at_rsp, rdata);
      else passed++;
    end
`ifdef WB_TIMEOUT_STATUS_EN
    total++;
    if (n_to !== int'(timed_out)) $display("FAIL %s timeout_pulse: got %0d, want %0d", name, n_to, timed_out);
    else passed++;
    total++;
    if (timeout_cnt_o !== 16'(exp_to_cnt)) $display("FAIL %s timeout_cnt: got %0d, want %0d", name, timeout_cnt_o, exp_to_cnt);
    else passed++;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    total++;
    if (!all_outputs_zero()) $display("FAIL reset_outputs: some output nonzero, want all 0");
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    run_txn(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 4'hF, 4, 3'b001, 32'h1234_5678, 0, "write");
  endtask

  task automatic test_timeout();
    run_txn(32'h0000_0040, 32'h0, 1'b0, 4'hF, 0, 3'b000, 32'h0, 0, "timeout");
    run_txn(32'h0000_0044, 32'h0, 1'b0, 4'h3, 18, 3'b001, 32'h0, 0, "late_ack");
  endtask

  task automatic test_race();
    run_txn(32'h0000_0048, 32'h0, 1'b0, 4'hF, TO, 3'b001, 32'h0BAD_F00D, 0, "race_ack");
    run_txn(32'h0000_004C, 32'h0, 1'b0, 4'hF, 2, 3'b111, 32'h0000_0007, 0, "prio_all");
    run_txn(32'h0000_0050, 32'h0, 1'b0, 4'hF, 3, 3'b110, 32'h0000_0006, 0, "prio_err");
    run_txn(32'h0000_0054, 32'h0, 1'b0, 4'hF, 1, 3'b100, 32'h0000_0004, 0, "rty");
  endtask

  task automatic test_abort();
    run_txn(32'h0000_0060, 32'h1111_2222, 1'b1, 4'hF, 0, 3'b000, 32'h0, 2, "abort");
    run_txn(32'h0000_0064, 32'h0, 1'b0, 4'hF, 3, 3'b001, 32'h3333_4444, 3, "abort_vs_ack");
    run_txn(32'h0000_0068, 32'h0, 1'b0, 4'hF, 2, 3'b001, 32'h5555_6666, 0, "after_abort");
  endtask

  // Read with ack on the first strobe cycle while the master keeps its strobe
  // up: the stale strobe must not be taken during RESP, only one cycle later.
  task automatic test_back_to_back();
    wbm_adr_i = 32'h20; wbm_dat_i = '0; wbm_we_i = 1'b0; wbm_sel_i = 4'hF;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (wbs_stb_o !== 1'b1) $display("FAIL b2b_stb_rise: got %b, want 1", wbs_stb_o);
    else passed++;
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hA5A5_0001;
    @(posedge clk); #1;
    wbs_ack_i = 1'b0; wbs_dat_i = 32'hFFFF_FFFF;
    total++;
    if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'hA5A5_0001)
      $display("FAIL b2b_read: ack %b dat %h, want 1 a5a50001", wbm_ack_o, wbm_dat_o);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (wbs_stb_o !== 1'b0 || wbm_ack_o !== 1'b0 || wbm_dat_o !== 32'hA5A5_0001)
      $display("FAIL b2b_gap: stb %b ack %b dat %h, want 0 0 a5a50001", wbs_stb_o, wbm_ack_o, wbm_dat_o);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (wbs_stb_o !== 1'b1) $display("FAIL b2b_reaccept: got %b, want 1", wbs_stb_o);
    else passed++;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (wbs_stb_o !== 1'b0 || wbs_cyc_o !== 1'b0 || wbm_ack_o !== 1'b0)
      $display("FAIL b2b_abort: stb %b cyc %b ack %b, want 0 0 0", wbs_stb_o, wbs_cyc_o, wbm_ack_o);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    wbm_adr_i = 32'h77; wbm_dat_i = 32'h88; wbm_we_i = 1'b1; wbm_sel_i = 4'h1;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (!all_outputs_zero()) $display("FAIL async_reset: outputs not cleared between edges, want all 0");
    else passed++;
    idle_inputs();
    exp_to_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 4'hF, 4, 3'b001, 32'h0, 0, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] adr, dat, rd;
      logic [3:0]  sel;
      logic [2:0]  fl;
      int k, a;
      adr = $urandom; dat = $urandom; rd = $urandom; sel = 4'($urandom);
      k  = $urandom_range(0, 20);
      fl = 3'($urandom_range(1, 7));
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : 0;
      run_txn(adr, dat, 1'($urandom), sel, k, fl, rd, a, "random");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_timeout();
    test_race();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
